// File: rtl/afifo_pkg.sv
// afifo_pkg: shared state encodings and data width default for the afifo read side
package afifo_pkg;
  localparam int DSIZE_DEF = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;
endpackage

// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: pops a FWFT afifo into a 2-entry skid buffer and presents a valid/ready stream
// Ports: i_clk/i_rst_n read-domain clock and async active-low reset; o_fifo_rd pop strobe,
// i_fifo_rdata/i_fifo_rempty afifo read side; o_valid/o_data/i_ready output stream;
// i_flush level-sensitive discard; o_busy state != IDLE; o_count handshakes delivered (wraps).
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int CW       = 16,
  parameter int EMPTY_QT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_fifo_rd,
  input  logic [DSIZE-1:0] i_fifo_rdata,
  input  logic             i_fifo_rempty,
  output logic             o_valid,
  output logic [DSIZE-1:0] o_data,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_busy,
  output logic [CW-1:0]    o_count
);
  localparam int EW = $clog2(EMPTY_QT + 1);
  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    erun_q, erun_d;
  logic             pop, push, cons;
  // pop depends only on registered state plus FIFO/flush inputs, never on i_ready
  always_comb begin
    pop     = !i_fifo_rempty && (state_q == ST_FLUSH || occ_q != 2'd2) && !i_flush;
    push    = pop && state_q != ST_FLUSH;
    cons    = (occ_q != 2'd0) && i_ready;
    occ_d   = i_flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, cons};
    head_d  = (push && (occ_q == 2'd0 || cons)) ? i_fifo_rdata
            : (cons && occ_q == 2'd2)           ? tail_q
            :                                     head_q;
    tail_d  = (push && occ_q == 2'd1 && !cons) ? i_fifo_rdata : tail_q;
    count_d = count_q + CW'(cons);
    // counts consecutive empty cycles seen while in FLUSH, saturating
    erun_d  = (state_q == ST_FLUSH && i_fifo_rempty)
            ? ((erun_q == EW'(EMPTY_QT)) ? erun_q : erun_q + EW'(1))
            : '0;
    state_d = i_flush                 ? ST_FLUSH
            : (state_q == ST_IDLE)    ? (pop ? ST_ACTIVE : ST_IDLE)
            : (state_q == ST_ACTIVE)  ? ((occ_d == 2'd0 && i_fifo_rempty) ? ST_IDLE : ST_ACTIVE)
            : (erun_d == EW'(EMPTY_QT)) ? ST_IDLE : ST_FLUSH;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      erun_q  <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      erun_q  <= erun_d;
    end
  end
  assign o_fifo_rd = pop;
  assign o_valid   = occ_q != 2'd0;
  assign o_data    = head_q;
  assign o_busy    = state_q != ST_IDLE;
  assign o_count   = count_q;
endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb_afifo_rd_stream: directed self-checking bench with a small FWFT FIFO model on the read clock
module tb_afifo_rd_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_rd, fifo_rempty, valid, ready, flush, busy;
  logic [7:0]  fifo_rdata, data;
  logic [15:0] count;
  logic [7:0]  mem [16];
  logic [3:0]  wp, rp;
  int          total = 0, bad = 0;

  afifo_rd_stream #(.DSIZE(8), .CW(16), .EMPTY_QT(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_fifo_rd(fifo_rd), .i_fifo_rdata(fifo_rdata),
    .i_fifo_rempty(fifo_rempty), .o_valid(valid), .o_data(data), .i_ready(ready),
    .i_flush(flush), .o_busy(busy), .o_count(count)
  );

  always #5 clk = ~clk;

  assign fifo_rempty = (wp == rp);
  assign fifo_rdata  = mem[rp];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rp <= '0;
    else if (fifo_rd) rp <= rp + 4'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 4'd1;
  endtask

  initial begin
    int k, nxt;
    logic saw;
    logic [7:0] t2 [3];
    t2[0] = 8'h12; t2[1] = 8'h13; t2[2] = 8'h14;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; ready = 1'b0; flush = 1'b0; wp = '0;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: three words, ready high, back-to-back delivery
    @(negedge clk);
    put(8'hAA); put(8'hBB); put(8'hCC); ready = 1'b1;
    @(negedge clk); chk("t1_v0", {31'd0, valid}, 32'd1); chk("t1_d0", {24'd0, data}, 32'hAA);
    @(negedge clk); chk("t1_v1", {31'd0, valid}, 32'd1); chk("t1_d1", {24'd0, data}, 32'hBB);
    @(negedge clk); chk("t1_v2", {31'd0, valid}, 32'd1); chk("t1_d2", {24'd0, data}, 32'hCC);
    @(negedge clk);
    chk("t1_valid_end", {31'd0, valid}, 32'd0);
    chk("t1_count", {16'd0, count}, 32'd3);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_rd", {31'd0, fifo_rd}, 32'd0);

    // 2: four queued words, ready low -> buffer fills to two and stops popping
    ready = 1'b0;
    put(8'h11); put(8'h12); put(8'h13); put(8'h14);
    repeat (3) @(negedge clk);
    chk("t2_left", {28'd0, wp - rp}, 32'd2);
    chk("t2_rd_full", {31'd0, fifo_rd}, 32'd0);
    chk("t2_valid", {31'd0, valid}, 32'd1);
    chk("t2_hold", {24'd0, data}, 32'h11);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_seq_v", {31'd0, valid}, 32'd1);
      chk("t2_seq_d", {24'd0, data}, {24'd0, t2[i]});
    end
    @(negedge clk);
    chk("t2_count", {16'd0, count}, 32'd7);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // 3: toggling ready over eight words, FIFO kept at most four deep
    k = 0; nxt = 0; ready = 1'b0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk);
      ready = ~ready;
      if (valid && ready) begin
        chk("t3_order", {24'd0, data}, k);
        k++;
      end
      if (nxt < 8 && (wp - rp) < 4'd4) begin
        put(8'(nxt));
        nxt++;
      end
    end
    chk("t3_delivered", k, 32'd8);
    @(negedge clk) ready = 1'b0;
    chk("t3_count", {16'd0, count}, 32'd15);
    chk("t3_valid_end", {31'd0, valid}, 32'd0);

    // 4: flush with two buffered and two queued words
    put(8'h21); put(8'h22); put(8'h23); put(8'h24);
    repeat (3) @(negedge clk);
    chk("t4_head", {24'd0, data}, 32'h21);
    flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    chk("t4_valid_drop", {31'd0, valid}, 32'd0);
    chk("t4_busy_flush", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_drained", {28'd0, wp - rp}, 32'd0);
    chk("t4_still_flush", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_count", {16'd0, count}, 32'd15);
    chk("t4_valid", {31'd0, valid}, 32'd0);

    // 5: empty FIFO, ready high -> no underflow pops
    ready = 1'b1; saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw = saw | fifo_rd | valid;
    end
    chk("t5_no_pop", {31'd0, saw}, 32'd0);
    chk("t5_count", {16'd0, count}, 32'd15);

    // 6: async reset with a full buffer, then a fresh word
    ready = 1'b0;
    put(8'h31); put(8'h32);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, valid}, 32'd0);
    chk("t6_rst_data", {24'd0, data}, 32'd0);
    chk("t6_rst_count", {16'd0, count}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; wp = '0;
    put(8'h5A); ready = 1'b1;
    @(negedge clk);
    chk("t6_v", {31'd0, valid}, 32'd1);
    chk("t6_d", {24'd0, data}, 32'h5A);
    @(negedge clk);
    chk("t6_count", {16'd0, count}, 32'd1);
    chk("t6_valid_end", {31'd0, valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
